fault_injectable_full_adder: RTL and testbench



---
 rtl/fault_injectable_full_adder.sv | 84 ++++++++
 tb/tb_fault_injectable_full_adder.sv | 111 +++++++++++
 2 files changed

// File: rtl/fault_injectable_full_adder.sv
// Gate-level full adder with selectable single-fault injection and a parallel
// fault-free reference; all outputs registered one cycle after sampling.
module fault_injectable_full_adder #(
  parameter int unsigned NUM_FAULTS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [7:0] err_in,
  output logic       sum,
  output logic       cout,
  output logic       fault_active,
  output logic       mismatch
);

  localparam int unsigned SEL_W = 8;

  localparam logic [SEL_W-1:0] F_X1_SA0 = SEL_W'(1);
  localparam logic [SEL_W-1:0] F_X1_SA1 = SEL_W'(2);
  localparam logic [SEL_W-1:0] F_G_SA0  = SEL_W'(3);
  localparam logic [SEL_W-1:0] F_G_SA1  = SEL_W'(4);
  localparam logic [SEL_W-1:0] F_P_SA0  = SEL_W'(5);
  localparam logic [SEL_W-1:0] F_P_SA1  = SEL_W'(6);
  localparam logic [SEL_W-1:0] F_S_INV  = SEL_W'(7);
  localparam logic [SEL_W-1:0] F_C_INV  = SEL_W'(8);

  logic       x1_c, s_c, g_c, p_c, c_c;
  logic [1:0] golden_c;
  logic       active_d;
  logic       sum_d, cout_d, mismatch_d;
  logic       sum_q, cout_q, fault_active_q, mismatch_q;

  // Faulted netlist: each forced net feeds every gate downstream of it.
  // Codes above NUM_FAULTS match none of the fault constants and behave as fault-free.
  always_comb begin
    x1_c = a ^ b;
    if (err_in == F_X1_SA0) x1_c = 1'b0;
    if (err_in == F_X1_SA1) x1_c = 1'b1;

    s_c = x1_c ^ cin;
    if (err_in == F_S_INV) s_c = ~s_c;

    g_c = a & b;
    if (err_in == F_G_SA0) g_c = 1'b0;
    if (err_in == F_G_SA1) g_c = 1'b1;

    p_c = x1_c & cin;
    if (err_in == F_P_SA0) p_c = 1'b0;
    if (err_in == F_P_SA1) p_c = 1'b1;

    c_c = g_c | p_c;
    if (err_in == F_C_INV) c_c = ~c_c;
  end

  // Reference result built arithmetically, independent of the netlist above.
  assign golden_c = 2'({1'b0, a}) + 2'({1'b0, b}) + 2'({1'b0, cin});

  assign active_d   = (err_in != '0) && (err_in <= SEL_W'(NUM_FAULTS));
  assign sum_d      = s_c;
  assign cout_d     = c_c;
  assign mismatch_d = ({c_c, s_c} != golden_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q          <= 1'b0;
      cout_q         <= 1'b0;
      fault_active_q <= 1'b0;
      mismatch_q     <= 1'b0;
    end else begin
      sum_q          <= sum_d;
      cout_q         <= cout_d;
      fault_active_q <= active_d;
      mismatch_q     <= mismatch_d;
    end
  end

  assign sum          = sum_q;
  assign cout         = cout_q;
  assign fault_active = fault_active_q;
  assign mismatch     = mismatch_q;

endmodule

// File: tb/tb_fault_injectable_full_adder.sv
// Directed bench for fault_injectable_full_adder: hand-derived {cout,sum}
// tables per fault code, out-of-range codes, and reset behaviour.
module tb_fault_injectable_full_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       a, b, cin;
  logic [7:0] err_in;
  logic       sum, cout, fault_active, mismatch;

  int n_total = 0;
  int n_bad   = 0;

  fault_injectable_full_adder dut (
    .clk          (clk),
    .rst          (rst),
    .a            (a),
    .b            (b),
    .cin          (cin),
    .err_in       (err_in),
    .sum          (sum),
    .cout         (cout),
    .fault_active (fault_active),
    .mismatch     (mismatch)
  );

  always #5 clk = ~clk;

  // Hand-derived {cout,sum} per code; 2-bit entry i at bits [2i+1:2i], i = {a,b,cin}.
  localparam logic [15:0] TAB [9] = '{
    16'b11_10_10_01_10_01_01_00,  // 0 fault-free
    16'b11_10_01_00_01_00_01_00,  // 1 x1 sa0
    16'b10_11_10_01_10_01_10_01,  // 2 x1 sa1
    16'b01_00_10_01_10_01_01_00,  // 3 g sa0
    16'b11_10_10_11_10_11_11_10,  // 4 g sa1
    16'b11_10_00_01_00_01_01_00,  // 5 p sa0
    16'b11_10_10_11_10_11_11_10,  // 6 p sa1
    16'b10_11_11_00_11_00_00_01,  // 7 s inverted
    16'b01_00_00_11_00_11_11_10   // 8 c inverted
  };

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Drive one sample away from the edge, then look at the outputs just after it.
  task automatic drive(input logic r, input logic [2:0] abc, input logic [7:0] code);
    @(negedge clk);
    rst    = r;
    a      = abc[2];
    b      = abc[1];
    cin    = abc[0];
    err_in = code;
    @(posedge clk);
    #1;
  endtask

  // Full 8-combination sweep for one selector value against table row tcode.
  task automatic sweep(input logic [7:0] code, input int tcode, input logic fa_exp);
    logic [15:0] row, ref_row;
    logic [1:0]  e, g;
    row     = TAB[tcode];
    ref_row = TAB[0];
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'(i), code);
      e = row[2*i +: 2];
      g = ref_row[2*i +: 2];
      check($sformatf("code%0d_abc%0d", code, i),
            {4'b0, fault_active, mismatch, cout, sum},
            {4'b0, fa_exp, (e != g), e});
      // Mismatch must agree with the observed outputs against the arithmetic sum.
      check($sformatf("mmprop%0d_abc%0d", code, i),
            {7'b0, mismatch},
            {7'b0, ({cout, sum} != (2'(a) + 2'(b) + 2'(cin)))});
    end
  endtask

  initial begin
    rst = 1'b1; a = 1'b0; b = 1'b0; cin = 1'b0; err_in = '0;
    drive(1'b1, 3'b000, 8'd0);
    drive(1'b1, 3'b111, 8'd7);
    check("reset_state", {4'b0, fault_active, mismatch, cout, sum}, 8'd0);

    for (int k = 0; k <= 8; k++)
      sweep(8'(k), k, (k != 0));
    sweep(8'd9,   0, 1'b0);
    sweep(8'd255, 0, 1'b0);

    // Put a nonzero value in flight, then reset over it.
    drive(1'b0, 3'b000, 8'd4);
    check("pre_reset", {4'b0, fault_active, mismatch, cout, sum}, 8'b0000_1110);
    drive(1'b1, 3'b111, 8'd4);
    check("mid_reset", {4'b0, fault_active, mismatch, cout, sum}, 8'd0);
    drive(1'b0, 3'b100, 8'd0);
    check("post_reset", {4'b0, fault_active, mismatch, cout, sum}, 8'b0000_0001);

    // Fault code and operands change together on one edge.
    drive(1'b0, 3'b111, 8'd7);
    check("switch_to_7", {4'b0, fault_active, mismatch, cout, sum}, 8'b0000_1110);
    drive(1'b0, 3'b111, 8'd0);
    check("switch_to_0", {4'b0, fault_active, mismatch, cout, sum}, 8'b0000_0011);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
